// File: rtl/ddr_boot_loader_if.sv
// Bus bundle for the DDR boot loader: boot request/done handshake,
// boot ROM read port and DDR controller write port.
interface ddr_boot_loader_if #(
  parameter int ROM_ADR_W = 10
);
  logic                 i_boot_req;
  logic                 o_boot_done;
  logic                 o_boot_err;
  logic                 o_rom_en;
  logic [ROM_ADR_W-1:0] o_rom_adr;
  logic [31:0]          i_rom_data;
  logic                 o_wr_valid;
  logic [31:0]          o_wr_adr;
  logic [31:0]          o_wr_data;
  logic                 i_wr_ready;

  modport master (
    input  i_boot_req, i_rom_data, i_wr_ready,
    output o_boot_done, o_boot_err, o_rom_en, o_rom_adr,
           o_wr_valid, o_wr_adr, o_wr_data
  );

  modport slave (
    output i_boot_req, i_rom_data, i_wr_ready,
    input  o_boot_done, o_boot_err, o_rom_en, o_rom_adr,
           o_wr_valid, o_wr_adr, o_wr_data
  );
endinterface

// File: rtl/ddr_boot_loader.sv
// Copies the boot image from ROM into DDR one word at a time after hard reset,
// accumulating a wrap-around checksum that must come out to zero.
module ddr_boot_loader #(
  parameter int          BOOT_WORDS = 1024,
  parameter int          ROM_ADR_W  = 10,
  parameter logic [31:0] DDR_BASE   = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  ddr_boot_loader_if.master     bus
);

  typedef enum logic [2:0] {IDLE, ISSUE, CAPTURE, WRITE, DONE} state_t;

  localparam logic [ROM_ADR_W-1:0] LAST_IDX = ROM_ADR_W'(BOOT_WORDS - 1);

  state_t               state, state_nxt;
  logic [ROM_ADR_W-1:0] idx, idx_nxt;
  logic [31:0]          sum, sum_nxt;
  logic                 done, done_nxt;
  logic                 err, err_nxt;
  logic                 rom_en, rom_en_nxt;
  logic [ROM_ADR_W-1:0] rom_adr, rom_adr_nxt;
  logic                 wr_valid, wr_valid_nxt;
  logic [31:0]          wr_adr, wr_adr_nxt;
  logic [31:0]          wr_data, wr_data_nxt;

  // Every output is a flop; the next-state logic below also computes the
  // next output values so each output is valid in the state it belongs to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      sum      <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
      rom_en   <= 1'b0;
      rom_adr  <= '0;
      wr_valid <= 1'b0;
      wr_adr   <= DDR_BASE;
      wr_data  <= '0;
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      sum      <= sum_nxt;
      done     <= done_nxt;
      err      <= err_nxt;
      rom_en   <= rom_en_nxt;
      rom_adr  <= rom_adr_nxt;
      wr_valid <= wr_valid_nxt;
      wr_adr   <= wr_adr_nxt;
      wr_data  <= wr_data_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    idx_nxt      = idx;
    sum_nxt      = sum;
    done_nxt     = done;
    err_nxt      = err;
    rom_en_nxt   = 1'b0;
    rom_adr_nxt  = rom_adr;
    wr_valid_nxt = wr_valid;
    wr_adr_nxt   = wr_adr;
    wr_data_nxt  = wr_data;

    case (state)
      IDLE: begin
        if (bus.i_boot_req) begin
          state_nxt   = ISSUE;
          rom_en_nxt  = 1'b1;
          rom_adr_nxt = idx;
        end else begin
          state_nxt = DONE;
          done_nxt  = 1'b1;
          err_nxt   = 1'b0;
        end
      end
      ISSUE: begin
        state_nxt = CAPTURE;
      end
      CAPTURE: begin
        state_nxt    = WRITE;
        wr_data_nxt  = bus.i_rom_data;
        wr_adr_nxt   = DDR_BASE + (32'(idx) << 2);
        sum_nxt      = sum + bus.i_rom_data;
        wr_valid_nxt = 1'b1;
      end
      WRITE: begin
        if (bus.i_wr_ready) begin
          wr_valid_nxt = 1'b0;
          // Terminal compare stops idx before it can wrap past the image end.
          if (idx == LAST_IDX) begin
            state_nxt = DONE;
            done_nxt  = 1'b1;
            err_nxt   = (sum != 32'd0);
          end else begin
            state_nxt   = ISSUE;
            idx_nxt     = idx + 1'b1;
            rom_en_nxt  = 1'b1;
            rom_adr_nxt = idx + 1'b1;
          end
        end
      end
      DONE: begin
        state_nxt = DONE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign bus.o_boot_done = done;
  assign bus.o_boot_err  = err;
  assign bus.o_rom_en    = rom_en;
  assign bus.o_rom_adr   = rom_adr;
  assign bus.o_wr_valid  = wr_valid;
  assign bus.o_wr_adr    = wr_adr;
  assign bus.o_wr_data   = wr_data;

endmodule

// File: tb/tb_ddr_boot_loader.sv
// Directed bench for ddr_boot_loader with a 4-word image: table of boot scenarios
// plus a hand-written mid-copy reset sequence.
module tb_ddr_boot_loader;

  localparam int          WORDS = 4;
  localparam int          AW    = 2;
  localparam logic [31:0] BASE  = 32'h0000_1000;

  typedef struct {
    string       name;
    logic        req;
    logic [31:0] last_word;
    int          stall_word;
    int          stall_len;
    int          drop_word;
    int          exp_done;
    logic        exp_err;
    int          exp_words;
  } vec_t;

  logic clk;
  logic rst;
  int   testsRun;
  int   testsFailed;

  logic [31:0] rom [WORDS];
  vec_t        vecs [5];

  ddr_boot_loader_if #(.ROM_ADR_W(AW)) bus ();

  ddr_boot_loader #(
    .BOOT_WORDS(WORDS),
    .ROM_ADR_W (AW),
    .DDR_BASE  (BASE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous ROM model: data valid the cycle after the read strobe.
  always @(posedge clk) begin
    if (bus.o_rom_en) bus.i_rom_data <= rom[bus.o_rom_adr];
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Resets the DUT, then runs one scenario cycle by cycle, sampling 1 ns after each edge.
  task automatic applyStimulus(input vec_t v);
    int w, stalls, firstDone, budget;
    bit presenting, stallNow;
    rom[0] = 32'd1;
    rom[1] = 32'd2;
    rom[2] = 32'd3;
    rom[3] = v.last_word;
    rst = 1'b1;
    bus.i_boot_req = v.req;
    bus.i_wr_ready = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    w = 0;
    stalls = 0;
    firstDone = -1;
    presenting = 1'b0;
    budget = v.exp_done + 4;
    for (int n = 0; n < budget; n++) begin
      if (n == 0) begin
        checkOutput({v.name, "_c0_done"}, 32'(bus.o_boot_done), 32'd0);
        checkOutput({v.name, "_c0_wr_adr"}, bus.o_wr_adr, BASE);
      end
      if (!v.req) begin
        checkOutput({v.name, "_skip_rom_en"}, 32'(bus.o_rom_en), 32'd0);
        checkOutput({v.name, "_skip_wr_valid"}, 32'(bus.o_wr_valid), 32'd0);
      end
      if (bus.o_rom_en && v.req) begin
        checkOutput({v.name, "_rom_adr"}, 32'(bus.o_rom_adr), 32'(w));
        checkOutput({v.name, "_rom_en_cycle"}, 32'(n), 32'(1 + 3 * w + stalls));
        checkOutput({v.name, "_rom_en_vs_valid"}, 32'(bus.o_wr_valid), 32'd0);
      end
      if (bus.o_wr_valid && v.req) begin
        if (!presenting) begin
          presenting = 1'b1;
          checkOutput({v.name, "_wr_cycle"}, 32'(n), 32'(3 + 3 * w + stalls));
        end
        checkOutput({v.name, "_wr_adr"}, bus.o_wr_adr, BASE + 32'(4 * w));
        checkOutput({v.name, "_wr_data"}, bus.o_wr_data, (w < WORDS) ? rom[w] : 32'hDEAD_BEEF);
      end
      if (bus.o_boot_done && firstDone < 0) firstDone = n;
      if (firstDone >= 0 && !bus.o_boot_done)
        checkOutput({v.name, "_done_sticky"}, 32'(bus.o_boot_done), 32'd1);
      stallNow = bus.o_wr_valid && (w == v.stall_word) && (stalls < v.stall_len);
      bus.i_wr_ready = !stallNow;
      if (bus.o_wr_valid && w == v.drop_word) bus.i_boot_req = 1'b0;
      if (bus.o_wr_valid && stallNow) stalls++;
      if (bus.o_wr_valid && !stallNow) begin
        w++;
        presenting = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    checkOutput({v.name, "_done_cycle"}, 32'(firstDone), 32'(v.exp_done));
    checkOutput({v.name, "_err"}, 32'(bus.o_boot_err), 32'(v.exp_err));
    checkOutput({v.name, "_words"}, 32'(w), 32'(v.exp_words));
  endtask

  initial begin
    int waited;
    testsRun = 0;
    testsFailed = 0;
    rst = 1'b1;
    bus.i_boot_req = 1'b0;
    bus.i_wr_ready = 1'b1;
    bus.i_rom_data = '0;

    vecs[0] = '{"good",   1'b1, 32'hFFFF_FFFA, -1, 0, -1, 13, 1'b0, 4};
    vecs[1] = '{"badsum", 1'b1, 32'hFFFF_FFFB, -1, 0, -1, 13, 1'b1, 4};
    vecs[2] = '{"skip",   1'b0, 32'hFFFF_FFFA, -1, 0, -1,  1, 1'b0, 0};
    vecs[3] = '{"stall",  1'b1, 32'hFFFF_FFFA,  1, 5, -1, 18, 1'b0, 4};
    vecs[4] = '{"drop",   1'b1, 32'hFFFF_FFFA, -1, 0,  1, 13, 1'b0, 4};

    for (int i = 0; i < 5; i++) applyStimulus(vecs[i]);

    // Mid-copy reset: hit rst while word 2 sits on the write bus.
    rst = 1'b1;
    bus.i_boot_req = 1'b1;
    bus.i_wr_ready = 1'b1;
    rom[3] = 32'hFFFF_FFFA;
    @(posedge clk);
    #1 rst = 1'b0;
    waited = 0;
    while (!(bus.o_wr_valid && bus.o_wr_adr == BASE + 32'd8) && waited < 30) begin
      @(posedge clk);
      #1 waited++;
    end
    checkOutput("midrst_reach_word2", 32'(waited < 30), 32'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("midrst_wr_valid", 32'(bus.o_wr_valid), 32'd0);
    checkOutput("midrst_wr_adr", bus.o_wr_adr, BASE);
    checkOutput("midrst_wr_data", bus.o_wr_data, 32'd0);
    checkOutput("midrst_rom_en", 32'(bus.o_rom_en), 32'd0);
    checkOutput("midrst_rom_adr", 32'(bus.o_rom_adr), 32'd0);
    checkOutput("midrst_done", 32'(bus.o_boot_done), 32'd0);
    checkOutput("midrst_err", 32'(bus.o_boot_err), 32'd0);
    vecs[0].name = "restart";
    applyStimulus(vecs[0]);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/ddr_boot_loader.md
# ddr_boot_loader

Copies the boot image from on-chip boot ROM into DDR after a hard reset, then reports completion to the reset manager. It is the responder side of the boot request/done handshake: the reset manager raises the boot request on hard reset and drops it when it sees a rising edge on boot-done. The block also checks the image checksum and flags a corrupt image. It sits in the DDR clock domain, between the boot ROM and the DDR controller write port.

## Interface

Parameters:
- BOOT_WORDS, 1024, number of 32-bit words in the image; must be ≥ 2.
- ROM_ADR_W, 10, ROM word-address width; 2^ROM_ADR_W ≥ BOOT_WORDS.
- DDR_BASE, 32'h0000_0000, DDR byte address of image word 0; must be 4-byte aligned.

Ports:
- clk  in  1  block clock.
- rst  in  1  asynchronous, active-high reset.
- i_boot_req  in  1  boot request from the reset manager; sampled only in IDLE.
- o_boot_done  out  1  boot finished or skipped; level, sticky until rst.
- o_boot_err  out  1  checksum mismatch; valid when o_boot_done=1, sticky until rst.
- o_rom_en  out  1  ROM read strobe.
- o_rom_adr  out  ROM_ADR_W  ROM word address.
- i_rom_data  in  32  ROM data, valid the cycle after o_rom_en=1.
- o_wr_valid  out  1  DDR write request.
- o_wr_adr  out  32  DDR byte address.
- o_wr_data  out  32  DDR write data.
- i_wr_ready  in  1  DDR write accept; a transfer occurs when o_wr_valid & i_wr_ready.

## Operation

- All outputs are registered.
- Reset values: o_boot_done=0, o_boot_err=0, o_rom_en=0, o_rom_adr=0, o_wr_valid=0, o_wr_adr=DDR_BASE, o_wr_data=0. Internal idx=0, sum=0, state=IDLE.
- FSM states: IDLE, ISSUE, CAPTURE, WRITE, DONE.
  - IDLE: if i_boot_req=1, go to ISSUE; otherwise go to DONE (skip boot, with o_boot_err=0).
  - ISSUE: o_rom_en=1 and o_rom_adr=idx for exactly this cycle; go to CAPTURE.
  - CAPTURE: i_rom_data is valid. At the clock edge, o_wr_data←i_rom_data, o_wr_adr←DDR_BASE+4·idx, sum←sum+i_rom_data (mod 2^32), o_wr_valid←1; go to WRITE.
  - WRITE: hold o_wr_valid, o_wr_adr and o_wr_data stable until i_wr_ready=1.
    - On the accept edge: o_wr_valid←0.
    - If idx=BOOT_WORDS−1: go to DONE.
    - Otherwise: idx←idx+1 and go to ISSUE.
  - DONE: o_boot_done=1 and o_boot_err=(sum≠0), both set on the entry edge. The block stays in DONE until rst.
- Checksum rule: the 32-bit wrap-around sum of all BOOT_WORDS words must equal 0. The final word is the complement word and is copied to DDR like every other word.
- i_boot_req is ignored outside IDLE. If it drops mid-copy, the copy continues.
- Only one write is outstanding at a time. o_rom_en is never asserted while o_wr_valid=1.
- A reset mid-operation clears all outputs immediately (asynchronously). The block restarts from IDLE, and a new copy begins at word 0 if i_boot_req=1.
- idx width is ROM_ADR_W. The terminal-count compare stops idx before it wraps.

## Timing

- Let E1 be the first rising edge after rst deasserts; cycle n is the interval after edge En.
- Boot path, with i_wr_ready tied to 1:
  - Cycle 1: ISSUE for word 0.
  - Cycle 2: CAPTURE.
  - Cycle 3: word 0 on the write bus.
  - Word k is presented in cycle 3+3k, so the steady cost is 3 cycles per word.
- The last accept happens in cycle 3·BOOT_WORDS. o_boot_done and o_boot_err rise together in cycle 3·BOOT_WORDS+1.
- Each stall cycle (i_wr_ready=0 while o_wr_valid=1) delays all later events by 1 cycle.
- Skip path: with i_boot_req=0 at E1, o_boot_done=1 in cycle 1 and no ROM or DDR activity occurs.
- The reset manager's edge detector needs a 0→1 transition on o_boot_done. o_boot_done is therefore 0 for at least cycle 0 after every reset.

## Test plan

- BOOT_WORDS=4, ROM={1,2,3,FFFFFFFA}, DDR_BASE=1000, i_wr_ready=1, i_boot_req=1 -> writes (1000,1),(1004,2),(1008,3),(100C,FFFFFFFA) in cycles 3,6,9,12; o_boot_done=1 and o_boot_err=0 in cycle 13.
- Same stimulus with the last word FFFFFFFB -> identical writes; o_boot_done=1 and o_boot_err=1 in cycle 13.
- i_boot_req=0 at reset release -> o_boot_done=1 in cycle 1, o_wr_valid and o_rom_en stay 0 throughout, o_boot_err=0.
- i_wr_ready=0 for 5 cycles while word 1 is presented -> o_wr_adr=1004 and o_wr_data=2 stay stable with o_rom_en=0; o_boot_done is delayed to cycle 18.
- Assert rst during WRITE of word 2, release it, i_boot_req=1 -> all outputs reset immediately; the copy restarts with word 0 in cycle 3 after the release and completes normally.
- Drop i_boot_req to 0 during word 1 -> the copy completes all 4 words and o_boot_done=1 in cycle 13.
